// File: rtl/cdb_slot_scheduler_if.sv
// Handshake bundle between the backend functional units and the CDB slot scheduler.
// The scheduler sits on the slave side; the unit queues and the Retire Bus sit on the master side.
interface cdb_slot_scheduler_if #(
  parameter int TAG_W = 5
);
  logic             ready_int0;
  logic             ready_int1;
  logic             ready_ls;
  logic             ready_mult;
  logic [TAG_W-1:0] mult_tag_in;
  logic             rb_flush_valid;
  logic             issue_int0;
  logic             issue_int1;
  logic             issue_ls;
  logic             issue_mult;
  logic [1:0]       cdb_sel;
  logic             cdb_sel_valid;
  logic [TAG_W-1:0] mult_tag_out;
  logic [3:0]       mult_inflight;

  modport master (
    output ready_int0, ready_int1, ready_ls, ready_mult, mult_tag_in, rb_flush_valid,
    input  issue_int0, issue_int1, issue_ls, issue_mult,
    input  cdb_sel, cdb_sel_valid, mult_tag_out, mult_inflight
  );

  modport slave (
    input  ready_int0, ready_int1, ready_ls, ready_mult, mult_tag_in, rb_flush_valid,
    output issue_int0, issue_int1, issue_ls, issue_mult,
    output cdb_sel, cdb_sel_valid, mult_tag_out, mult_inflight
  );
endinterface

// File: rtl/cdb_slot_scheduler.sv
// Shares the single CDB between Int0, Int1, LS and the pipelined multiplier.
// Multiplies reserve their future CDB slot through a tag delay line; the other units share round-robin.
module cdb_slot_scheduler #(
  parameter int MULT_LAT = 4,
  parameter int TAG_W    = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  cdb_slot_scheduler_if.slave bus
);

  localparam int STAGES = MULT_LAT - 1;

  localparam logic [1:0] UNIT_INT0 = 2'd0;
  localparam logic [1:0] UNIT_INT1 = 2'd1;
  localparam logic [1:0] UNIT_LS   = 2'd2;
  localparam logic [1:0] UNIT_MULT = 2'd3;

  logic [STAGES-1:0] stage_valid;
  logic [TAG_W-1:0]  stage_tag [STAGES];
  logic              mult_due;
  logic [1:0]        rr_ptr;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        rr_next;
  logic              flush;

  assign flush    = bus.rb_flush_valid;
  assign mult_due = stage_valid[STAGES-1];

  // First ready single-cycle unit at or after rr_ptr, unless a multiply owns next cycle's slot.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = UNIT_INT0;
    if (rst_n && !mult_due && !flush) begin
      case (rr_ptr)
        UNIT_INT1: begin
          if (bus.ready_int1)      begin grant_valid = 1'b1; grant_idx = UNIT_INT1; end
          else if (bus.ready_ls)   begin grant_valid = 1'b1; grant_idx = UNIT_LS;   end
          else if (bus.ready_int0) begin grant_valid = 1'b1; grant_idx = UNIT_INT0; end
        end
        UNIT_LS: begin
          if (bus.ready_ls)        begin grant_valid = 1'b1; grant_idx = UNIT_LS;   end
          else if (bus.ready_int0) begin grant_valid = 1'b1; grant_idx = UNIT_INT0; end
          else if (bus.ready_int1) begin grant_valid = 1'b1; grant_idx = UNIT_INT1; end
        end
        default: begin
          if (bus.ready_int0)      begin grant_valid = 1'b1; grant_idx = UNIT_INT0; end
          else if (bus.ready_int1) begin grant_valid = 1'b1; grant_idx = UNIT_INT1; end
          else if (bus.ready_ls)   begin grant_valid = 1'b1; grant_idx = UNIT_LS;   end
        end
      endcase
    end
  end

  always_comb begin
    case (grant_idx)
      UNIT_INT0: rr_next = UNIT_INT1;
      UNIT_INT1: rr_next = UNIT_LS;
      default:   rr_next = UNIT_INT0;
    endcase
  end

  assign bus.issue_int0 = grant_valid && (grant_idx == UNIT_INT0);
  assign bus.issue_int1 = grant_valid && (grant_idx == UNIT_INT1);
  assign bus.issue_ls   = grant_valid && (grant_idx == UNIT_LS);
  assign bus.issue_mult = rst_n && bus.ready_mult && !flush;

  // Tags shift every cycle; only the valids are cleared by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int i = 0; i < STAGES; i++) stage_tag[i] <= '0;
    end else begin
      stage_valid[0] <= bus.issue_mult;
      stage_tag[0]   <= bus.mult_tag_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_tag[i]   <= stage_tag[i-1];
      end
      if (flush) stage_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr            <= UNIT_INT0;
      bus.cdb_sel       <= UNIT_INT0;
      bus.cdb_sel_valid <= 1'b0;
      bus.mult_tag_out  <= '0;
    end else begin
      if (grant_valid) rr_ptr <= rr_next;
      if (flush) begin
        bus.cdb_sel_valid <= 1'b0;
      end else if (mult_due) begin
        bus.cdb_sel       <= UNIT_MULT;
        bus.mult_tag_out  <= stage_tag[STAGES-1];
        bus.cdb_sel_valid <= 1'b1;
      end else if (grant_valid) begin
        bus.cdb_sel       <= grant_idx;
        bus.cdb_sel_valid <= 1'b1;
      end else begin
        bus.cdb_sel_valid <= 1'b0;
      end
    end
  end

  // Count drops when a multiply lands on the CDB; simultaneous issue and landing cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mult_inflight <= '0;
    end else if (flush) begin
      bus.mult_inflight <= '0;
    end else begin
      case ({bus.issue_mult, mult_due})
        2'b10:   bus.mult_inflight <= bus.mult_inflight + 4'd1;
        2'b01:   bus.mult_inflight <= bus.mult_inflight - 4'd1;
        default: bus.mult_inflight <= bus.mult_inflight;
      endcase
    end
  end

endmodule

// File: doc/cdb_slot_scheduler.md
Name: cdb_slot_scheduler

Overview:
- Shares the single CDB between the four backend functional units: Int0 ALU, Int1 ALU, LS/DCache, and the pipelined multiplier.
- Issues at most one single-cycle unit per cycle, chosen round-robin.
- Reserves CDB slots for in-flight multiplies and carries each multiply's Rd tag down a delay line matching the multiplier latency.
- Drives the registered CDB source-select used by the CDB output mux, and takes the Retire Bus flush.

Parameters:
- MULT_LAT, 4, cycles from Issue_Mult to the multiply result being on the CDB (legal range 2..8).
- TAG_W, 5, Rd tag width.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Ready_Int0  in  1  Int0 issue queue has a ready entry.
- Ready_Int1  in  1  Int1 issue queue has a ready entry.
- Ready_LS  in  1  DCache has a result ready.
- Ready_Mult  in  1  Mult issue queue has a ready entry.
- Mult_Tag_In  in  TAG_W  Rd tag of the Mult queue head entry; sampled when Issue_Mult=1.
- RB_Flush_Valid  in  1  flush request from the Retire Bus.
- Issue_Int0  out  1  grant to Int0; combinational.
- Issue_Int1  out  1  grant to Int1; combinational.
- Issue_LS  out  1  grant to LS; combinational.
- Issue_Mult  out  1  grant to Mult; combinational.
- CDB_Sel  out  2  registered CDB source select: 0=Int0, 1=Int1, 2=LS, 3=Mult.
- CDB_Sel_Valid  out  1  registered; CDB carries a valid result this cycle.
- Mult_Tag_Out  out  TAG_W  registered; tag of the multiply result on the CDB; meaningful only when CDB_Sel=3 and CDB_Sel_Valid=1.
- Mult_InFlight  out  4  registered count of multiplies issued and not yet on the CDB.

Behaviour:
- Timing:
  - A single-cycle unit issued in cycle t owns the CDB in cycle t+1.
  - A Mult issued in cycle t owns the CDB in cycle t+MULT_LAT.
- Mult delay line: MULT_LAT-1 stages, each holding a valid bit and a TAG_W tag, shifting every cycle.
  - Stage 1 loads {Issue_Mult, Mult_Tag_In}.
  - The last stage drives the CDB register.
  - mult_due = valid bit of the stage that reaches the CDB next cycle.
- Issue_Mult = Ready_Mult & ~RB_Flush_Valid.
  - Multiplies never collide with each other, so back-to-back issue is allowed.
- Single-cycle arbitration:
  - Blocked entirely (all three Issue_* low) when mult_due=1 or RB_Flush_Valid=1.
  - Otherwise, grant the first ready requester in round-robin order starting at rr_ptr (order Int0 -> Int1 -> LS -> Int0).
  - Exactly one grant when any requester is ready.
- rr_ptr (2-bit, values 0..2):
  - After a grant it moves to the unit following the granted one.
  - It is unchanged on cycles with no single-cycle grant.
  - It never takes the value 3.
- CDB register, updated each edge:
  - mult_due=1: CDB_Sel<=3, Mult_Tag_Out<=tag of that stage, CDB_Sel_Valid<=1.
  - Else, if a single-cycle grant occurred: CDB_Sel<=index of the granted unit, CDB_Sel_Valid<=1.
  - Else: CDB_Sel_Valid<=0 and CDB_Sel holds its value.
- Flush (RB_Flush_Valid=1 in cycle t):
  - All Issue_* are 0 in cycle t.
  - All delay-line valids clear at the edge, and Mult_InFlight<=0.
  - CDB_Sel_Valid=0 in cycle t+1.
  - A CDB result already registered for cycle t is unaffected.
  - rr_ptr is retained.
- Mult_InFlight:
  - +1 on Issue_Mult, -1 when a multiply reaches the CDB; both in the same cycle means no change.
  - Never exceeds MULT_LAT.
- Reset (Rst=0, async, any time including mid-multiply):
  - All delay-line valids=0, tags=0.
  - rr_ptr=0, CDB_Sel=0, CDB_Sel_Valid=0, Mult_Tag_Out=0, Mult_InFlight=0.
  - Issue_* are forced to 0 while Rst=0.
  - Normal operation resumes on the first edge after deassertion.
- All Ready inputs low: no grants; rr_ptr holds.

Test Plan:
- Reset mid-operation: multiply in flight, pull Rst low asynchronously mid-cycle -> all outputs 0 immediately; after release with Ready_Int1=1 only -> Issue_Int1 in the first cycle, CDB_Sel=1 with Valid=1 next cycle.
- Round-robin: Ready_Int0/Int1/LS all held 1 from cycle 5 -> grants Int0, Int1, LS, Int0 at cycles 5..8; CDB_Sel=0,1,2,0 at cycles 6..9.
- Mult reservation, MULT_LAT=4: Ready_Mult pulse at cycle 10 with tag 0x0B, Ready_Int0 held 1 -> Issue_Int0=0 at cycle 13; cycle 14 shows CDB_Sel=3, Mult_Tag_Out=0x0B; Issue_Int0=1 at cycle 14, CDB_Sel=0 at cycle 15.
- Back-to-back mults: Ready_Mult at cycles 10..12 with tags 1, 2, 3 -> CDB_Sel=3 at cycles 14, 15, 16 with tags 1, 2, 3; all single-cycle issues blocked in cycles 13..15; Mult_InFlight peaks at 3.
- Flush: mult issued at cycle 10 with tag 7, RB_Flush_Valid at cycle 12 -> no Issue_* at cycle 12; Mult_InFlight=0 at cycle 13; CDB_Sel_Valid=0 at cycle 14.
- Single requester: only Ready_LS=1 for 6 cycles -> Issue_LS every cycle, CDB_Sel=2 with Valid=1 continuously one cycle later.
